afe_udma_tx_if: RTL
===================

// Module: afe_udma_tx_if
// PURPOSE
// - Sits directly upstream of the per-subchannel L2 address generators (type1).
// - Accepts tagged ADC samples and fetches the current L2 address of the sample's subchannel.
// - Issues one 32-bit uDMA write per sample.
// - Returns the udma_vtransfer/udma_subch_id pulse that advances the selected address generator.
// - Samples for disabled subchannels are dropped and counted.
// PARAMETERS
// AWIDTH              18  L2 address width
// ADC_SUBCH_ID_WIDTH  2   subchannel id width
// N_SUBCH             4   number of subchannels (<= 2**ADC_SUBCH_ID_WIDTH)
// DROP_CNT_WIDTH      16  width of dropped-sample counter
// PORTS
// clk_i              in   1                  clock
// rstn_i             in   1                  async reset, active low
// sample_valid_i     in   1                  sample available
// sample_ready_o     out  1                  block can accept sample
// sample_data_i      in   32                 ADC sample word
// sample_subch_id_i  in   ADC_SUBCH_ID_WIDTH target subchannel of sample
// cfg_curr_addr_i    in   N_SUBCH*AWIDTH     current address per subch (subch k at [k*AWIDTH +: AWIDTH])
// cfg_en_i           in   N_SUBCH            enable per subch (addr gen cfg_en_o)
// udma_req_o         out  1                  uDMA write request
// udma_gnt_i         in   1                  uDMA grant
// udma_addr_o        out  AWIDTH             write address
// udma_data_o        out  32                 write data
// udma_datasize_o    out  2                  constant 2'b10 (word)
// udma_vtransfer_o   out  1                  valid transfer pulse to addr gens
// udma_subch_id_o    out  ADC_SUBCH_ID_WIDTH subch of current transfer
// drop_clr_i         in   1                  clear drop counter
// drop_cnt_o         out  DROP_CNT_WIDTH     dropped-sample count, saturating
// BEHAVIOUR
// - One clock; reset is asynchronous and active-low. Reset clears all registers.
// - Reset values: state IDLE, udma_req_o=0, udma_addr_o=0, udma_data_o=0, udma_subch_id_o=0, drop_cnt_o=0.
// - Therefore udma_vtransfer_o=0 and sample_ready_o=1 out of reset.
// - FSM IDLE:
//   - sample_ready_o=1 (combinational: state==IDLE); udma_req_o=0.
//   - On sample_valid_i and cfg_en_i[id]: latch data, id, and cfg_curr_addr_i[id]; go to REQ.
//   - On sample_valid_i and !cfg_en_i[id], or id>=N_SUBCH: consume the sample, drop it, stay in IDLE.
//   - The drop increments drop_cnt_o, saturating at all-ones.
// - FSM REQ:
//   - sample_ready_o=0; udma_req_o=1.
//   - addr, data and subch_id outputs are held stable until grant; the request is never withdrawn.
//   - On udma_gnt_i: return to IDLE.
// - udma_vtransfer_o = udma_req_o & udma_gnt_i (combinational, same cycle as grant).
//   - The address generator updates on that edge.
//   - The next IDLE cycle therefore sees the advanced address; no stale-address hazard.
// - Throughput: at most one accepted sample per 2 cycles. Accept-to-req latency is 1 cycle.
// - The address is latched at accept. A change on cfg_curr_addr_i (reload, clr) during REQ does not affect the pending write.
// - If cfg_en_i[id] falls during REQ, the write still completes and vtransfer still pulses.
//   - The disabled address generator ignores the pulse.
// - If drop_clr_i and a drop occur in the same cycle, clear wins: drop_cnt_o=0.
// - Reset asserted mid-REQ: the request is dropped immediately and the latched sample is lost.
// TESTING
// - Addr gen k=1 at 0x100, en: sample 0xDEADBEEF id1.
//   -> next cycle req=1, addr=0x100, data=0xDEADBEEF; gnt -> vtransfer=1, subch_id=1 for 1 cycle.
// - Back-to-back id1 samples, gnt same cycle as req, real type1 addr gen attached.
//   -> writes go to 0x100, 0x104, 0x108; one accept per 2 cycles.
// - cfg_en_i=4'b0001, sample id2.
//   -> no req, ready stays 1, drop_cnt 0->1; with drop_clr_i in the same cycle -> 0.
// - Grant withheld 5 cycles while sample_valid_i=1.
//   -> ready=0, addr/data stable all 5 cycles, exactly one vtransfer at grant.
// - Drive 0xFFFF drops, then one more.
//   -> drop_cnt_o saturates at 0xFFFF.
// - Assert rstn_i low during REQ.
//   -> req=0 and drop_cnt=0 asynchronously; after release, ready=1 and no spurious vtransfer.

Source files
------------

// File: rtl/afe_udma_tx_if.sv
// afe_udma_tx_if: turns tagged ADC samples into one uDMA word write each, fetching the
// L2 address from the sample's subchannel address generator and dropping disabled ones.
module afe_udma_tx_if #(
    parameter int AWIDTH             = 18,
    parameter int ADC_SUBCH_ID_WIDTH = 2,
    parameter int N_SUBCH            = 4,
    parameter int DROP_CNT_WIDTH     = 16
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          sample_valid_i,
    output logic                          sample_ready_o,
    input  logic [31:0]                   sample_data_i,
    input  logic [ADC_SUBCH_ID_WIDTH-1:0] sample_subch_id_i,
    input  logic [N_SUBCH*AWIDTH-1:0]     cfg_curr_addr_i,
    input  logic [N_SUBCH-1:0]            cfg_en_i,
    output logic                          udma_req_o,
    input  logic                          udma_gnt_i,
    output logic [AWIDTH-1:0]             udma_addr_o,
    output logic [31:0]                   udma_data_o,
    output logic [1:0]                    udma_datasize_o,
    output logic                          udma_vtransfer_o,
    output logic [ADC_SUBCH_ID_WIDTH-1:0] udma_subch_id_o,
    input  logic                          drop_clr_i,
    output logic [DROP_CNT_WIDTH-1:0]     drop_cnt_o
);
    typedef enum logic {IDLE, REQ} state_t;

    state_t                          r_state, w_state_nxt;
    logic [AWIDTH-1:0]               r_addr;
    logic [31:0]                     r_data;
    logic [ADC_SUBCH_ID_WIDTH-1:0]   r_subch;
    logic [DROP_CNT_WIDTH-1:0]       r_drop_cnt;
    logic                            w_en, w_accept, w_drop;

    // Ids beyond the implemented subchannels count as disabled.
    assign w_en     = (int'(sample_subch_id_i) < N_SUBCH) && cfg_en_i[sample_subch_id_i];
    assign w_accept = (r_state == IDLE) && sample_valid_i && w_en;
    assign w_drop   = (r_state == IDLE) && sample_valid_i && !w_en;

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == IDLE)
            w_state_nxt = w_accept ? REQ : IDLE;
        else
            w_state_nxt = udma_gnt_i ? IDLE : REQ;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Address is captured at accept so later generator reloads cannot corrupt the pending write.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_addr     <= '0;
            r_data     <= '0;
            r_subch    <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= cfg_curr_addr_i[sample_subch_id_i*AWIDTH +: AWIDTH];
                r_data  <= sample_data_i;
                r_subch <= sample_subch_id_i;
            end
            if (drop_clr_i)
                r_drop_cnt <= '0;
            else if (w_drop && r_drop_cnt != '1)
                r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign sample_ready_o   = (r_state == IDLE);
    assign udma_req_o       = (r_state == REQ);
    assign udma_vtransfer_o = udma_req_o & udma_gnt_i;
    assign udma_addr_o      = r_addr;
    assign udma_data_o      = r_data;
    assign udma_subch_id_o  = r_subch;
    assign udma_datasize_o  = 2'b10;
    assign drop_cnt_o       = r_drop_cnt;
endmodule
